risc_mc_control: RTL and testbench
==================================

# risc_mc_control

Multi-cycle control unit for the 16-bit RISC core, the successor to the single-cycle opcode decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and holds each step until the instruction and data memories acknowledge it. It adds bus-timeout detection, an illegal-opcode mode and a retired-instruction counter. It sits between the instruction register, PC logic, register file, ALU and the RAM port.

## Interface
- OPCODE_W, 4: opcode width; opcodes above 4'b1101 are unassigned.
- ILLEGAL_TRAP, 1: 1 = unassigned opcodes raise `illegal` and retire as no-op; 0 = legacy behaviour, decoded as data-processing.
- MEM_TIMEOUT, 16: maximum MEM-state cycles without `dmem_ready`; 0 disables the timeout.
- CNT_W, 16: width of `instr_count`.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  IR opcode field, sampled only on the fetch handshake.
- imem_valid  in  1  instruction word valid.
- dmem_ready  in  1  data memory access complete.
- zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- ir_load, pc_write  out  1  IR load strobe and PC write strobe.
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
- alu_op  out  2  00 = funct-driven, 01 = subtract/compare, 10 = address add.
- alu_src, dest_reg, mem_to_reg, reg_write, ram_read, write_enable  out  1  datapath controls, same meaning as in the single-cycle core.
- retire, illegal, bus_error  out  1  one-cycle event pulses.
- instr_count  out  CNT_W  count of retired instructions; wraps.

## Operation
- Opcode classes:
  - 0000: LW.
  - 0001: SW.
  - 0010–1001: data-processing (DP).
  - 1011: BEQ.
  - 1100: BNE.
  - 1101: JMP.
  - Anything else: ILL when ILLEGAL_TRAP=1, otherwise DP.
- `opcode_q` latches `opcode` when in FETCH with `imem_valid`=1. All later states decode only `opcode_q`.
- Outputs are Moore, a function of state and `opcode_q`. An output not listed for a state is 0.
- FETCH:
  - Outputs: `imem_req`=1.
  - Transition: on `imem_valid`, pulse `ir_load`=1 and `pc_write`=1 (pc_src 00), then go to DECODE. Otherwise stay.
- DECODE: LW/SW/DP go to EXEC; BEQ/BNE go to BRANCH; JMP goes to JUMP; ILL pulses `illegal`+`retire` and goes to FETCH.
- EXEC:
  - LW/SW: `alu_op`=10, `alu_src`=1, then go to MEM.
  - DP: `alu_op`=00, then go to WB.
- MEM:
  - Outputs: `alu_op`=10, `alu_src`=1, plus `ram_read`=1 (LW) or `write_enable`=1 (SW), held until `dmem_ready`.
  - On `dmem_ready`: LW goes to WB; SW pulses `retire` and goes to FETCH.
- WB:
  - Outputs: `reg_write`=1; `dest_reg`=1 for DP, 0 for LW; `mem_to_reg`=1 for LW.
  - Transition: pulse `retire`, go to FETCH.
- BRANCH:
  - Outputs: `alu_op`=01, `pc_src`=01, `pc_write`=(BEQ&zero)|(BNE&!zero).
  - Transition: pulse `retire`, go to FETCH.
- JUMP: `pc_write`=1, `pc_src`=10, pulse `retire`, go to FETCH.
- Timeout:
  - `wait_cnt` clears on MEM entry and increments each MEM cycle without `dmem_ready`.
  - When `wait_cnt`=MEM_TIMEOUT−1 and `dmem_ready`=0: pulse `bus_error`, do not retire, go to FETCH, and drop `ram_read`/`write_enable` on the next cycle.
  - If `dmem_ready` arrives in that same cycle, it wins and no error is raised.
- `instr_count` increments by 1 on each `retire` and wraps from 2^CNT_W−1 to 0.

## Timing
- Minimum cycles per instruction, with zero wait states: DP 4, LW 5, SW 4, BEQ/BNE/JMP 3, ILL 2.
- Each `imem_valid` or `dmem_ready` wait cycle adds exactly one cycle.
- `retire`, `illegal` and `bus_error` are high for exactly one cycle, in the final state of the instruction.
- Reset:
  - While `reset`=1, every output is 0, including `imem_req`.
  - At the next edge: state=FETCH, `opcode_q`=0, `wait_cnt`=0, `instr_count`=0.
  - `imem_req` rises in the first cycle after reset deasserts.
- Reset mid-MEM: the access is abandoned with no retire, and `write_enable` is 0 from the reset cycle on.
- `opcode` changing outside the fetch handshake has no effect.

## Structure
- `risc_pkg` holds:
  - state enum `mc_state_t` (FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP);
  - opcode constants (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP);
  - `alu_op` constants (ALU_FUNCT, ALU_SUB, ALU_ADD);
  - `pc_src` constants;
  - class enum `op_class_t` (LW, SW, DP, BEQ, BNE, JMP, ILL).
- Sub-module `risc_op_class`: combinational map from opcode to `op_class_t`, honouring ILLEGAL_TRAP. The FSM, the counters and the output decode stay in `risc_mc_control`.

## Test plan
- Reset, then DP 0010 with `imem_valid` held high → `ir_load` in cycle 1, `reg_write`=1 and `dest_reg`=1 in cycle 4, `retire` in cycle 4, `instr_count`=1.
- LW 0000 with `dmem_ready` delayed 3 cycles → `ram_read` high for 4 cycles, then WB with `mem_to_reg`=1, total 8 cycles.
- BEQ with `zero`=1 and BNE with `zero`=1 → `pc_write`=1 with `pc_src`=01 for BEQ; `pc_write`=0 for BNE; both retire in 3 cycles.
- SW with `dmem_ready` never asserted and MEM_TIMEOUT=4 → `write_enable` high for 4 cycles, `bus_error` pulses in the 4th, no retire, FETCH next.
- Opcode 1111: ILLEGAL_TRAP=1 → `illegal`+`retire` in DECODE and no `reg_write`; ILLEGAL_TRAP=0 → DP flow with `reg_write`=1.
- Reset asserted during an LW MEM wait → all outputs 0 next cycle, `instr_count`=0; CNT_W=2 with 5 retires → `instr_count`=1.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and constants for the multi-cycle RISC control unit.
// Contents: FSM state enum, opcode constants, ALU-op and PC-source
// encodings, and the opcode class enum produced by risc_op_class.
package risc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        BRANCH,
        JUMP
    } mc_state_t;

    typedef enum logic [2:0] {
        LW,
        SW,
        DP,
        BEQ,
        BNE,
        JMP,
        ILL
    } op_class_t;

    // Opcode map; 0010..1001 is the data-processing range, 1010 and
    // 1110..1111 are unassigned.
    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_DP_LO = 4'b0010;
    localparam logic [3:0] OP_DP_HI = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;

    localparam logic [1:0] ALU_FUNCT = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_ADD   = 2'b10;

    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Width of the MEM-state wait counter; covers any 16-bit MEM_TIMEOUT.
    localparam int WAIT_W = 16;

endpackage

// File: rtl/risc_mc_control_if.sv
// Bus bundle between the control unit and the datapath / memories.
// master: the control unit (receives opcode, memory handshakes, zero flag;
//         drives strobes, datapath controls, event pulses, instr_count).
// slave : the datapath side (the reverse directions).
interface risc_mc_control_if #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                imem_valid;
    logic                dmem_ready;
    logic                zero;

    logic                imem_req;
    logic                ir_load;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic [1:0]          alu_op;
    logic                alu_src;
    logic                dest_reg;
    logic                mem_to_reg;
    logic                reg_write;
    logic                ram_read;
    logic                write_enable;
    logic                retire;
    logic                illegal;
    logic                bus_error;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, imem_valid, dmem_ready, zero,
        output imem_req, ir_load, pc_write, pc_src, alu_op, alu_src,
               dest_reg, mem_to_reg, reg_write, ram_read, write_enable,
               retire, illegal, bus_error, instr_count
    );

    modport slave (
        output opcode, imem_valid, dmem_ready, zero,
        input  imem_req, ir_load, pc_write, pc_src, alu_op, alu_src,
               dest_reg, mem_to_reg, reg_write, ram_read, write_enable,
               retire, illegal, bus_error, instr_count
    );
endinterface

// File: rtl/risc_op_class.sv
// Combinational opcode classifier.
// Ports: opcode (in, OPCODE_W) -> op_class (out, op_class_t).
// Unassigned opcodes map to ILL when ILLEGAL_TRAP != 0, else to DP.
module risc_op_class
    import risc_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    always_comb begin
        // NOTE: assign a default before any branch; a path that leaves the
        // output unassigned would infer a latch.
        op_class = (ILLEGAL_TRAP != 0) ? ILL : DP;
        if (opcode == OPCODE_W'(OP_LW))
            op_class = LW;
        else if (opcode == OPCODE_W'(OP_SW))
            op_class = SW;
        else if (opcode >= OPCODE_W'(OP_DP_LO) && opcode <= OPCODE_W'(OP_DP_HI))
            op_class = DP;
        else if (opcode == OPCODE_W'(OP_BEQ))
            op_class = BEQ;
        else if (opcode == OPCODE_W'(OP_BNE))
            op_class = BNE;
        else if (opcode == OPCODE_W'(OP_JMP))
            op_class = JMP;
    end

endmodule

// File: rtl/risc_mc_control.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB (or BRANCH/JUMP), waits on imem_valid and
// dmem_ready, aborts stalled MEM accesses after MEM_TIMEOUT cycles, and
// counts retired instructions.
// Ports: clk, reset (sync, active-high), bus (risc_mc_control_if.master).
module risc_mc_control
    import risc_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int ILLEGAL_TRAP = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    risc_mc_control_if.master     bus
);

    mc_state_t           state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_class_t           op_class;
    logic                timeout_hit;

    logic       imem_req, ir_load, pc_write, alu_src, dest_reg, mem_to_reg;
    logic       reg_write, ram_read, write_enable, retire, illegal, bus_error;
    logic [1:0] pc_src, alu_op;

    // Every post-fetch decision uses the latched opcode, never the live input.
    risc_op_class #(
        .OPCODE_W     (OPCODE_W),
        .ILLEGAL_TRAP (ILLEGAL_TRAP)
    ) u_op_class (
        .opcode   (opcode_q),
        .op_class (op_class)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) &&
                         (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        wait_cnt_d   = wait_cnt_q;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS1;
        alu_op       = ALU_FUNCT;
        alu_src      = 1'b0;
        dest_reg     = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        ram_read     = 1'b0;
        write_enable = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        bus_error    = 1'b0;

        // Outputs are forced low for the whole reset cycle, so an access in
        // flight is dropped immediately rather than at the next edge.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (bus.imem_valid) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                        opcode_d = bus.opcode;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    case (op_class)
                        LW, SW, DP: state_d = EXEC;
                        BEQ, BNE:   state_d = BRANCH;
                        JMP:        state_d = JUMP;
                        default: begin
                            illegal = 1'b1;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                    endcase
                end
                EXEC: begin
                    if (op_class == LW || op_class == SW) begin
                        alu_op     = ALU_ADD;
                        alu_src    = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = MEM;
                    end else begin
                        state_d = WB;
                    end
                end
                MEM: begin
                    alu_op       = ALU_ADD;
                    alu_src      = 1'b1;
                    ram_read     = (op_class == LW);
                    write_enable = (op_class == SW);
                    // A late dmem_ready in the timeout cycle still completes.
                    if (bus.dmem_ready) begin
                        if (op_class == LW) begin
                            state_d = WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                    end else if (timeout_hit) begin
                        bus_error = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    dest_reg   = (op_class == DP);
                    mem_to_reg = (op_class == LW);
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
                BRANCH: begin
                    alu_op   = ALU_SUB;
                    pc_src   = PC_BRANCH;
                    pc_write = (op_class == BEQ &&  bus.zero) ||
                               (op_class == BNE && !bus.zero);
                    retire   = 1'b1;
                    state_d  = FETCH;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end

        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= FETCH;
            opcode_q   <= '0;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_req     = imem_req;
    assign bus.ir_load      = ir_load;
    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.alu_op       = alu_op;
    assign bus.alu_src      = alu_src;
    assign bus.dest_reg     = dest_reg;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.reg_write    = reg_write;
    assign bus.ram_read     = ram_read;
    assign bus.write_enable = write_enable;
    assign bus.retire       = retire;
    assign bus.illegal      = illegal;
    assign bus.bus_error    = bus_error;
    assign bus.instr_count  = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_risc_mc_control.sv
// Scoreboard bench for risc_mc_control. Two instances:
//   dut_a: ILLEGAL_TRAP=1, MEM_TIMEOUT=4, CNT_W=2
//   dut_b: ILLEGAL_TRAP=0, MEM_TIMEOUT=0 (timeout disabled), CNT_W=16
// Stimulus drives one cycle per step and pushes that cycle's expected
// output bundle; the monitor pops and compares on the falling edge.
module tb_risc_mc_control;
    import risc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b;

    risc_mc_control_if #(.OPCODE_W(4), .CNT_W(2))  if_a ();
    risc_mc_control_if #(.OPCODE_W(4), .CNT_W(16)) if_b ();

    risc_mc_control #(
        .OPCODE_W(4), .ILLEGAL_TRAP(1), .MEM_TIMEOUT(4), .CNT_W(2)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a.master)
    );

    risc_mc_control #(
        .OPCODE_W(4), .ILLEGAL_TRAP(0), .MEM_TIMEOUT(0), .CNT_W(16)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b.master)
    );

    typedef struct packed {
        logic        imem_req;
        logic        ir_load;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        dest_reg;
        logic        mem_to_reg;
        logic        reg_write;
        logic        ram_read;
        logic        write_enable;
        logic        retire;
        logic        illegal;
        logic        bus_error;
        logic [15:0] instr_count;
    } out_t;

    typedef struct {
        out_t  exp;
        string tag;
    } sb_t;

    sb_t q_a[$];
    sb_t q_b[$];
    int  vectors     = 0;
    int  miscompares = 0;

    // ---------------- expected-value builders (hand-specified) ----------
    function automatic out_t e_base(input int c);
        out_t o = '0;
        o.instr_count = 16'(c);
        return o;
    endfunction

    function automatic out_t e_fetch(input bit v, input int c);
        out_t o = e_base(c);
        o.imem_req = 1'b1;
        o.ir_load  = v;
        o.pc_write = v;
        return o;
    endfunction

    function automatic out_t e_dec(input bit ill, input int c);
        out_t o = e_base(c);
        o.illegal = ill;
        o.retire  = ill;
        return o;
    endfunction

    function automatic out_t e_exec(input bit mem, input int c);
        out_t o = e_base(c);
        if (mem) begin
            o.alu_op  = 2'b10;
            o.alu_src = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t e_mem(input bit lw, input bit ret, input bit berr, input int c);
        out_t o = e_base(c);
        o.alu_op       = 2'b10;
        o.alu_src      = 1'b1;
        o.ram_read     = lw;
        o.write_enable = !lw;
        o.retire       = ret;
        o.bus_error    = berr;
        return o;
    endfunction

    function automatic out_t e_wb(input bit dp, input int c);
        out_t o = e_base(c);
        o.reg_write  = 1'b1;
        o.dest_reg   = dp;
        o.mem_to_reg = !dp;
        o.retire     = 1'b1;
        return o;
    endfunction

    function automatic out_t e_br(input bit pcw, input int c);
        out_t o = e_base(c);
        o.alu_op   = 2'b01;
        o.pc_src   = 2'b01;
        o.pc_write = pcw;
        o.retire   = 1'b1;
        return o;
    endfunction

    function automatic out_t e_jmp(input int c);
        out_t o = e_base(c);
        o.pc_write = 1'b1;
        o.pc_src   = 2'b10;
        o.retire   = 1'b1;
        return o;
    endfunction

    // ---------------- stimulus ------------------------------------------
    task automatic step(input bit sel_b, input bit rst, input logic [3:0] op,
                        input bit iv, input bit dr, input bit z,
                        input out_t e, input string tag);
        sb_t s;
        @(posedge clk);
        #1;
        s.exp = e;
        s.tag = tag;
        if (!sel_b) begin
            reset_a = rst; if_a.opcode = op; if_a.imem_valid = iv;
            if_a.dmem_ready = dr; if_a.zero = z;
            q_a.push_back(s);
        end else begin
            reset_b = rst; if_b.opcode = op; if_b.imem_valid = iv;
            if_b.dmem_ready = dr; if_b.zero = z;
            q_b.push_back(s);
        end
    endtask

    task automatic sa(input bit rst, input logic [3:0] op, input bit iv,
                      input bit dr, input bit z, input out_t e, input string tag);
        step(1'b0, rst, op, iv, dr, z, e, tag);
    endtask

    task automatic sb(input bit rst, input logic [3:0] op, input bit iv,
                      input bit dr, input bit z, input out_t e, input string tag);
        step(1'b1, rst, op, iv, dr, z, e, tag);
    endtask

    // ---------------- monitor -------------------------------------------
    task automatic cmp(input string dut, input sb_t s, input out_t act);
        vectors++;
        if (act !== s.exp) begin
            miscompares++;
            $display("FAIL %s %s: got %h expected %h", dut, s.tag, act, s.exp);
        end
    endtask

    function automatic out_t pack_a();
        out_t o;
        o.imem_req = if_a.imem_req;   o.ir_load = if_a.ir_load;
        o.pc_write = if_a.pc_write;   o.pc_src = if_a.pc_src;
        o.alu_op = if_a.alu_op;       o.alu_src = if_a.alu_src;
        o.dest_reg = if_a.dest_reg;   o.mem_to_reg = if_a.mem_to_reg;
        o.reg_write = if_a.reg_write; o.ram_read = if_a.ram_read;
        o.write_enable = if_a.write_enable; o.retire = if_a.retire;
        o.illegal = if_a.illegal;     o.bus_error = if_a.bus_error;
        o.instr_count = 16'(if_a.instr_count);
        return o;
    endfunction

    function automatic out_t pack_b();
        out_t o;
        o.imem_req = if_b.imem_req;   o.ir_load = if_b.ir_load;
        o.pc_write = if_b.pc_write;   o.pc_src = if_b.pc_src;
        o.alu_op = if_b.alu_op;       o.alu_src = if_b.alu_src;
        o.dest_reg = if_b.dest_reg;   o.mem_to_reg = if_b.mem_to_reg;
        o.reg_write = if_b.reg_write; o.ram_read = if_b.ram_read;
        o.write_enable = if_b.write_enable; o.retire = if_b.retire;
        o.illegal = if_b.illegal;     o.bus_error = if_b.bus_error;
        o.instr_count = if_b.instr_count;
        return o;
    endfunction

    initial begin
        sb_t s;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                s = q_a.pop_front();
                cmp("dut_a", s, pack_a());
            end
            if (q_b.size() > 0) begin
                s = q_b.pop_front();
                cmp("dut_b", s, pack_b());
            end
        end
    end

    // ---------------- directed sequence ---------------------------------
    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        if_a.opcode = '0; if_a.imem_valid = 1'b0; if_a.dmem_ready = 1'b0; if_a.zero = 1'b0;
        if_b.opcode = '0; if_b.imem_valid = 1'b0; if_b.dmem_ready = 1'b0; if_b.zero = 1'b0;

        // Reset: every output low.
        sa(1, 4'b0000, 0, 0, 0, e_base(0), "reset0");
        sa(1, 4'b0000, 0, 0, 0, e_base(0), "reset1");

        // DP 0010 with imem_valid held high: 4 cycles.
        sa(0, 4'b0010, 1, 0, 0, e_fetch(1, 0), "dp_fetch");
        sa(0, 4'b0010, 1, 0, 0, e_dec(0, 0),   "dp_decode");
        sa(0, 4'b0010, 1, 0, 0, e_exec(0, 0),  "dp_exec");
        sa(0, 4'b0010, 0, 0, 0, e_wb(1, 0),    "dp_wb");

        // LW with dmem_ready 3 cycles late; ready lands on the timeout
        // cycle and must win.
        sa(0, 4'b0000, 1, 0, 0, e_fetch(1, 1),      "lw_fetch_cnt1");
        sa(0, 4'b0000, 0, 0, 0, e_dec(0, 1),        "lw_decode");
        sa(0, 4'b0000, 0, 0, 0, e_exec(1, 1),       "lw_exec");
        sa(0, 4'b0000, 0, 0, 0, e_mem(1, 0, 0, 1),  "lw_mem_w0");
        sa(0, 4'b0000, 0, 0, 0, e_mem(1, 0, 0, 1),  "lw_mem_w1");
        sa(0, 4'b0000, 0, 0, 0, e_mem(1, 0, 0, 1),  "lw_mem_w2");
        sa(0, 4'b0000, 0, 1, 0, e_mem(1, 0, 0, 1),  "lw_mem_ready_at_limit");
        sa(0, 4'b0000, 0, 0, 0, e_wb(0, 1),         "lw_wb");

        // BEQ with zero=1: taken.
        sa(0, 4'b1011, 1, 0, 1, e_fetch(1, 2), "beq_fetch");
        sa(0, 4'b1011, 0, 0, 1, e_dec(0, 2),   "beq_decode");
        sa(0, 4'b1011, 0, 0, 1, e_br(1, 2),    "beq_taken");

        // BNE with zero=1: not taken; retire wraps the 2-bit count.
        sa(0, 4'b1100, 1, 0, 1, e_fetch(1, 3), "bne_fetch");
        sa(0, 4'b1100, 0, 0, 1, e_dec(0, 3),   "bne_decode");
        sa(0, 4'b1100, 0, 0, 1, e_br(0, 3),    "bne_not_taken");

        // SW, dmem_ready never: bus_error on the 4th MEM cycle, no retire.
        sa(0, 4'b0001, 1, 0, 0, e_fetch(1, 0),     "sw_fetch_wrapped");
        sa(0, 4'b0001, 0, 0, 0, e_dec(0, 0),       "sw_decode");
        sa(0, 4'b0001, 0, 0, 0, e_exec(1, 0),      "sw_exec");
        sa(0, 4'b0001, 0, 0, 0, e_mem(0, 0, 0, 0), "sw_mem_w0");
        sa(0, 4'b0001, 0, 0, 0, e_mem(0, 0, 0, 0), "sw_mem_w1");
        sa(0, 4'b0001, 0, 0, 0, e_mem(0, 0, 0, 0), "sw_mem_w2");
        sa(0, 4'b0001, 0, 0, 0, e_mem(0, 0, 1, 0), "sw_bus_error");
        sa(0, 4'b1111, 0, 0, 0, e_fetch(0, 0),     "after_bus_error_fetch_wait");

        // Opcode 1111 with trap enabled: illegal + retire in DECODE.
        sa(0, 4'b1111, 1, 0, 0, e_fetch(1, 0), "ill_fetch");
        sa(0, 4'b1111, 0, 0, 0, e_dec(1, 0),   "ill_decode_trap");

        // JMP.
        sa(0, 4'b1101, 1, 0, 0, e_fetch(1, 1), "jmp_fetch");
        sa(0, 4'b1101, 0, 0, 0, e_dec(0, 1),   "jmp_decode");
        sa(0, 4'b1101, 0, 0, 0, e_jmp(1),      "jmp_exec");

        // DP fetched, then opcode input switched to SW: no effect.
        sa(0, 4'b0011, 1, 0, 0, e_fetch(1, 2), "opchg_fetch");
        sa(0, 4'b0001, 0, 1, 0, e_dec(0, 2),   "opchg_decode");
        sa(0, 4'b0001, 0, 1, 0, e_exec(0, 2),  "opchg_exec_dp");
        sa(0, 4'b0001, 0, 1, 0, e_wb(1, 2),    "opchg_wb_dp");

        // Reset during an LW MEM wait: outputs low at once, count cleared.
        sa(0, 4'b0000, 1, 0, 0, e_fetch(1, 3),     "rstmem_fetch");
        sa(0, 4'b0000, 0, 0, 0, e_dec(0, 3),       "rstmem_decode");
        sa(0, 4'b0000, 0, 0, 0, e_exec(1, 3),      "rstmem_exec");
        sa(0, 4'b0000, 0, 0, 0, e_mem(1, 0, 0, 3), "rstmem_mem");
        sa(1, 4'b0000, 0, 0, 0, e_base(0),         "rstmem_reset_cycle");
        sa(0, 4'b0000, 0, 0, 0, e_fetch(0, 0),     "rstmem_after_reset");

        // Five retires on a 2-bit counter: 0,1,2,3,0 -> 1.
        for (int i = 0; i < 5; i++) begin
            sa(0, 4'b1110, 1, 0, 0, e_fetch(1, i % 4), "wrap_fetch");
            sa(0, 4'b1110, 0, 0, 0, e_dec(1, i % 4),   "wrap_ill");
        end
        sa(0, 4'b0000, 0, 0, 0, e_fetch(0, 1), "wrap_result");

        // dut_b: opcode 1111 with trap disabled decodes as DP.
        sb(1, 4'b0000, 0, 0, 0, e_base(0),     "b_reset");
        sb(0, 4'b1111, 1, 0, 0, e_fetch(1, 0), "b_ill_fetch");
        sb(0, 4'b1111, 0, 0, 0, e_dec(0, 0),   "b_ill_decode_no_trap");
        sb(0, 4'b1111, 0, 0, 0, e_exec(0, 0),  "b_ill_exec_dp");
        sb(0, 4'b1111, 0, 0, 0, e_wb(1, 0),    "b_ill_wb_dp");

        // dut_b: timeout disabled, SW waits 6 cycles then completes.
        sb(0, 4'b0001, 1, 0, 0, e_fetch(1, 1), "b_sw_fetch");
        sb(0, 4'b0001, 0, 0, 0, e_dec(0, 1),   "b_sw_decode");
        sb(0, 4'b0001, 0, 0, 0, e_exec(1, 1),  "b_sw_exec");
        for (int i = 0; i < 6; i++)
            sb(0, 4'b0001, 0, 0, 0, e_mem(0, 0, 0, 1), "b_sw_mem_wait");
        sb(0, 4'b0001, 0, 1, 0, e_mem(0, 1, 0, 1), "b_sw_mem_ready");
        sb(0, 4'b0000, 0, 0, 0, e_fetch(0, 2),     "b_after_sw");

        @(negedge clk);
        #1;
        vectors++;
        if (q_a.size() + q_b.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", q_a.size() + q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
